fetch_unit: RTL and testbench

//  Instruction fetch front end: the requester side of the prog_mem read interface.

---
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the prog_mem word address from the fetch PC and
// buffers fetched words with their byte PCs in a small FIFO handed to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [31:0]                   mem_addr,
  input  logic [31:0]                   mem_data,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [31:0]                   instr,
  output logic [31:0]                   instr_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [31:0]   PC_MASK  = 32'hFFFF_FFFC;

  logic [31:0]   fetch_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [31:0]   word_buf [FIFO_DEPTH];
  logic [31:0]   pc_buf   [FIFO_DEPTH];
  logic          vld;
  logic          pop;
  logic          push;

  assign vld  = (level != '0);
  assign pop  = vld & instr_ready;
  // A pop frees the slot the incoming word takes, so a full FIFO keeps streaming.
  assign push = !redirect_valid & ((level < FULL_LVL) | pop);

  // Control state: fetch PC, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC & PC_MASK;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & PC_MASK;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Buffer storage: payload only, occupancy above decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      word_buf[wr_ptr] <= mem_data;
      pc_buf[wr_ptr]   <= fetch_pc;
    end
  end

  assign mem_addr    = {2'b00, fetch_pc[31:2]};
  assign instr_valid = vld;
  assign instr       = vld ? word_buf[rd_ptr] : 32'd0;
  assign instr_pc    = vld ? pc_buf[rd_ptr]   : 32'd0;
  assign fifo_level  = level;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a queue-based
// reference model compared against the DUT every cycle.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [1:0]  fifo_level;

  logic [31:0] w_mem_addr, w_mem_data;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'd0;
  logic        w_instr_valid;
  logic        w_instr_ready = 1'b1;
  logic [31:0] w_instr, w_instr_pc;
  logic [1:0]  w_fifo_level;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign mem_data   = 32'hA000_0000 + mem_addr;
  assign w_mem_data = 32'hA000_0000 + w_mem_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .fifo_level(fifo_level)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .reset(reset), .mem_addr(w_mem_addr), .mem_data(w_mem_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
    .instr(w_instr), .instr_pc(w_instr_pc), .fifo_level(w_fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, word} entries and the next PC to fetch.
  typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;
  entry_t      q[$];
  logic [31:0] mpc = 32'd0;

  always @(posedge clk) begin
    bit do_pop, do_push;
    if (reset) begin
      q.delete();
      mpc = 32'h0000_0000;
    end else begin
      do_pop  = (q.size() > 0) && instr_ready;
      do_push = !redirect_valid && ((q.size() < DEPTH) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (redirect_valid) begin
        q.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (do_push) begin
        q.push_back('{pc: mpc, word: 32'hA000_0000 + (mpc >> 2)});
        mpc = mpc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", {31'd0, instr_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
      chk("model_level", {30'd0, fifo_level}, q.size());
      chk("model_addr", mem_addr, mpc >> 2);
      chk("model_instr", instr, (q.size() > 0) ? q[0].word : 32'd0);
      chk("model_pc", instr_pc, (q.size() > 0) ? q[0].pc : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    // 1: reset and free-running stream; the second instance checks PC wrap.
    tick();
    chk_en = 1'b1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_level", {30'd0, fifo_level}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("wrap_rst_addr", w_mem_addr, 32'h3FFF_FFFE);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s1_valid", {31'd0, instr_valid}, 32'd1);
      chk("s1_pc", instr_pc, 32'(i * 4));
      chk("s1_instr", instr, 32'hA000_0000 + 32'(i));
    end
    chk("wrap_pc0", w_instr_pc, 32'h0000_0004);

    // 2: stall with decode not ready.
    reset = 1'b1; instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("s2_level", {30'd0, fifo_level}, 32'd2);
    chk("s2_addr", mem_addr, 32'd2);
    chk("s2_pc", instr_pc, 32'd0);
    chk("s2_instr", instr, 32'hA000_0000);
    instr_ready = 1'b1;
    tick();
    chk("s2_resume1", instr_pc, 32'd4);
    tick();
    chk("s2_resume2", instr_pc, 32'd8);
    chk("s2_level_full", {30'd0, fifo_level}, 32'd2);

    // 3: redirect while full.
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("s3_valid", {31'd0, instr_valid}, 32'd0);
    chk("s3_addr", mem_addr, 32'd16);
    tick();
    chk("s3_pc", instr_pc, 32'h40);
    chk("s3_instr", instr, 32'hA000_0010);

    // 4: unaligned redirect together with a pop.
    tick();
    chk("s4_full", {30'd0, fifo_level}, 32'd2);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect_valid = 1'b0;
    chk("s4_valid", {31'd0, instr_valid}, 32'd0);
    chk("s4_addr", mem_addr, 32'd16);
    tick();
    chk("s4_pc", instr_pc, 32'h40);
    chk("s4_instr", instr, 32'hA000_0010);

    // 6: reset mid-stream with a full FIFO, then a randomized run.
    instr_ready = 1'b0;
    tick(); tick();
    chk("s6_full", {30'd0, fifo_level}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_valid", {31'd0, instr_valid}, 32'd0);
    chk("s6_level", {30'd0, fifo_level}, 32'd0);
    chk("s6_addr", mem_addr, 32'd0);
    for (int i = 0; i < 400; i++) begin
      instr_ready    = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(9) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : 32'($urandom_range(4095));
      reset          = ($urandom_range(49) == 0);
      tick();
    end
    reset = 1'b0; redirect_valid = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // 5: wrap sequence of the second instance, sampled alongside scenario 1.
  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wrap_seq0", w_instr_pc, 32'hFFFF_FFF8);
    chk("wrap_word0", w_instr, 32'hA000_0000 + 32'h3FFF_FFFE);
    @(posedge clk); #1;
    chk("wrap_seq1", w_instr_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_seq2", w_instr_pc, 32'h0000_0000);
    chk("wrap_word2", w_instr, 32'hA000_0000);
    chk("wrap_addr", w_mem_addr, 32'd1);
  end

endmodule
